// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with fixed wait states.
// Holds each load/store for LATENCY cycles and stalls the datapath.
//
// Parameters:
//   n        data and address width
//   DEPTH    number of n-bit words (power of two, >= 2)
//   LATENCY  wait-state cycles per access (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   memread    load request
//   memwrite   store request (wins over memread)
//   addr       byte address (word index = addr[$clog2(DEPTH)+1:2])
//   writedata  store data
//   readdata   registered load data, held until the next load
//   stall      high while an access is outstanding
//   misaligned sticky flag, only with DMEM_ALIGN_CHECK_EN defined
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN

module dmem_responder #(
   parameter int n       = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memread,
   input  logic         memwrite,
   input  logic [n-1:0] addr,
   input  logic [n-1:0] writedata,
   output logic [n-1:0] readdata,
`ifdef DMEM_ALIGN_CHECK_EN
   output logic         stall,
   output logic         misaligned
`else
   output logic         stall
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_d;

   logic [AW-1:0]  lat_idx;
   logic [n-1:0]   lat_data;
   logic           lat_wr;

   logic           capture;
   logic           access;

   logic [n-1:0]   mem [DEPTH];

   // Address bits outside the word index never affect the access.
   logic           unused_addr;
   assign unused_addr = ^{addr[n-1:AW+2], addr[1:0]};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      stall   = 1'b0;
      capture = 1'b0;
      access  = 1'b0;
      unique case (state_q)
         IDLE: begin
            stall = memread | memwrite;
            if (memread | memwrite) begin
               capture = 1'b1;
               count_d = CW'(LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            stall   = 1'b1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               access  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Requests here belong to the retiring instruction.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Reset wins over a request seen combinationally in IDLE.
      if (!reset) begin
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_idx  <= '0;
         lat_data <= '0;
         lat_wr   <= 1'b0;
      end else if (capture) begin
         lat_idx  <= addr[AW+1:2];
         lat_data <= writedata;
         // A simultaneous read+write is a plain store.
         lat_wr   <= memwrite;
      end
   end

   // Storage has no reset; an access cut off by reset never
   // reaches WAIT with count 1, so no write happens.
   always_ff @(posedge clk) begin
      if (access && lat_wr) begin
         mem[lat_idx] <= lat_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata <= '0;
      end else if (access && !lat_wr) begin
         readdata <= mem[lat_idx];
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misaligned <= 1'b0;
      end else if (capture && (addr[1:0] != 2'b00)) begin
         misaligned <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus random load/store sequences
// checked against a word-map reference model.

module tb_dmem_responder;

   localparam int N   = 32;
   localparam int DEP = 64;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          memread;
   logic          memwrite;
   logic [N-1:0]  addr;
   logic [N-1:0]  writedata;
   logic [N-1:0]  readdata;
   logic          stall;
`ifdef DMEM_ALIGN_CHECK_EN
   logic          misaligned;
`endif

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [N-1:0] ref_mem [int];
   logic [N-1:0] ref_rd;

   dmem_responder #(
      .n       (N),
      .DEPTH   (DEP),
      .LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .memread   (memread),
      .memwrite  (memwrite),
      .addr      (addr),
      .writedata (writedata),
      .readdata  (readdata),
`ifdef DMEM_ALIGN_CHECK_EN
      .stall     (stall),
      .misaligned(misaligned)
`else
      .stall     (stall)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [N-1:0] got,
                        input logic [N-1:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int widx(input logic [N-1:0] a);
      return int'((a / 4) % DEP);
   endfunction

   // One complete transaction: request held through DONE, inputs
   // scrambled during WAIT, then released for one idle cycle.
   task automatic xact(input bit rd, input bit wr,
                       input logic [N-1:0] a,
                       input logic [N-1:0] d,
                       input string tag);
      int cyc;
      @(negedge clk);
      memread   = rd;
      memwrite  = wr;
      addr      = a;
      writedata = d;
      #1;
      cyc = 0;
      while (stall && cyc < 50) begin
         cyc++;
         @(negedge clk);
         addr      = $urandom;
         writedata = $urandom;
         #1;
      end
      check({tag, "_stall_cycles"}, N'(cyc), N'(LAT + 1));
      if (wr) ref_mem[widx(a)] = d;
      else if (rd) ref_rd = ref_mem[widx(a)];
      check({tag, "_done_rd"}, readdata, ref_rd);
      memread  = 1'b0;
      memwrite = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "_idle_stall"}, N'(stall), N'(0));
      check({tag, "_hold_rd"}, readdata, ref_rd);
   endtask

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] d;
      int           k;

      reset     = 1'b0;
      memread   = 1'b1;
      memwrite  = 1'b1;
      addr      = 32'h8;
      writedata = 32'h0;
      ref_rd    = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall", N'(stall), N'(0));
      check("reset_rd", readdata, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
      check("reset_mis", N'(misaligned), N'(0));
`endif
      memread  = 1'b0;
      memwrite = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      xact(0, 1, 32'h8,   32'hABCD1234, "st8");
      xact(1, 0, 32'h8,   32'h0,        "ld8");
      repeat (3) @(negedge clk);
      check("ld8_hold_idle", readdata, 32'hABCD1234);

      xact(0, 1, 32'h4,   32'h11111111, "st4");
      xact(1, 0, 32'h104, 32'h0,        "ld104_wrap");
      check("wrap_value", readdata, 32'h11111111);

      xact(1, 0, 32'h8,   32'h0,        "ld8b");
      xact(1, 1, 32'hC,   32'h5A5A5A5A, "rdwr");
      check("rdwr_unchanged", readdata, 32'hABCD1234);
      xact(1, 0, 32'hC,   32'h0,        "ldC");
      check("ldC_value", readdata, 32'h5A5A5A5A);

      // Reset in the second WAIT cycle of a store drops it.
      xact(0, 1, 32'h10,  32'h0BADF00D, "st10");
      @(negedge clk);
      memwrite  = 1'b1;
      addr      = 32'h10;
      writedata = 32'hDEADBEEF;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_stall", N'(stall), N'(0));
      check("midrst_rd", readdata, 32'h0);
      ref_rd   = '0;
      memwrite = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      xact(1, 0, 32'h10,  32'h0,        "ld10_dropped");
      check("dropped_value", readdata, 32'h0BADF00D);

`ifdef DMEM_ALIGN_CHECK_EN
      check("mis_after_rst", N'(misaligned), N'(0));
      xact(1, 0, 32'h6,   32'h0,        "ld6_mis");
      check("ld6_word1", readdata, 32'h11111111);
      check("mis_set", N'(misaligned), N'(1));
      xact(1, 0, 32'h8,   32'h0,        "ld8_aligned");
      check("mis_sticky", N'(misaligned), N'(1));
`endif

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         d = $urandom;
         k = widx(a);
         if (ref_mem.exists(k) && ($urandom_range(0, 1) == 1)) begin
            xact(1, 0, a, d, "rnd_ld");
         end else begin
            xact(1'($urandom_range(0, 1)), 1, a, d, "rnd_st");
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory that answers the load/store requests the single-cycle datapath issues on `aluout`/`writedata`. It holds each access for a fixed number of wait states and returns `readdata` with a `stall` signal, so the datapath can freeze `pc` and the register file until the access completes. It sits between the datapath's memory port and the top-level CPU wrapper, in place of the zero-latency behavioural memory.

## Interface
Parameters:
- `n`, 32, data and address width in bits
- `DEPTH`, 64, number of n-bit words; power of two, at least 2
- `LATENCY`, 2, wait-state cycles per access; must be at least 1

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `memread`  in  1  load request from the controller
- `memwrite`  in  1  store request from the controller
- `addr`  in  n  byte address, driven from datapath `aluout`
- `writedata`  in  n  store data, driven from datapath `writedata`
- `readdata`  out  n  registered load data, to datapath `readdata`
- `stall`  out  1  high while an access is outstanding; the datapath must hold `pc` and suppress `regwrite`

## Operation
- One clock domain with asynchronous active-low reset. There is a single clock and one reset.
- Word index is `addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH`. `addr[1:0]` is ignored.
- The storage array has no reset. Contents are X until written.
- FSM states:
  - IDLE:
    - `stall = memread | memwrite` (combinational).
    - On a request, latch `addr`, `writedata` and the op, load `count = LATENCY`, then go to WAIT.
  - WAIT:
    - `stall = 1`.
    - `count` decrements each cycle.
    - When `count == 1`, perform the access on that edge and go to DONE.
    - A store writes the array. A load loads `readdata` from the array.
  - DONE:
    - `stall = 0`.
    - Request inputs are ignored, because they belong to the instruction retiring this cycle.
    - Always go to IDLE.
- `memread` and `memwrite` high together: treated as a store only; `readdata` is unchanged.
- Inputs changing during WAIT have no effect, since only the latched copies are used.
- `readdata` holds its value until the next load completes. A store does not change it.

## Timing
- Reset values: state IDLE, `count = 0`, `readdata = 0`, `stall = 0`. Reset forces `stall` to 0 regardless of the request inputs.
- Reset asserted mid-access: the FSM returns to IDLE immediately and the pending access is dropped (no array write). `readdata` is cleared to 0.
- Request seen in cycle T (IDLE):
  - `stall` is high in cycles T through T+LATENCY, which is LATENCY+1 cycles.
  - The access occurs at the end of cycle T+LATENCY.
  - DONE is cycle T+LATENCY+1. In DONE, `readdata` is valid and `stall = 0`; the datapath commits at the end of this cycle.
- Back-to-back requests: the earliest next capture is cycle T+LATENCY+2 (IDLE).
- `LATENCY = 1`: IDLE goes to WAIT for one cycle, then to DONE. `stall` is high for 2 cycles.
- `stall` depends combinationally on `memread` and `memwrite`, but only in IDLE. There is no combinational path from `addr` or `writedata` to any output.

## Configuration
- `DMEM_ALIGN_CHECK_EN`, when defined:
  - Adds the output port `misaligned` (1 bit).
  - `misaligned` is a sticky flag, set at capture when the latched `addr[1:0] != 0`, and cleared only by reset. Its reset value is 0.
  - The access still proceeds at the truncated word index.
- When not defined: the port and its logic are absent, and misaligned addresses are silently word-truncated.

## Test plan
- Reset, then store `addr=0x8`, `writedata=0xABCD1234`, `LATENCY=2`:
  - `stall` is high for exactly 3 cycles, then low in DONE.
  - `readdata` stays 0.
- Load `addr=0x8` after the store above:
  - `stall` is high for 3 cycles.
  - In DONE, `readdata=0xABCD1234`, and it holds through following idle cycles.
- Store `0x11111111` to `addr=0x4`, then load `addr=0x104` (`DEPTH=64`): `readdata=0x11111111` (address wrap).
- `memread=memwrite=1`, `addr=0xC`, `writedata=0x5A5A5A5A`, prior `readdata=0xABCD1234`:
  - `readdata` stays `0xABCD1234`.
  - A later load from `0xC` returns `0x5A5A5A5A`.
- Store to `0x10` with `reset` pulled low in the second WAIT cycle:
  - `stall` is 0 and `readdata` is 0 immediately.
  - After reset is released, a load from `0x10` does not return the dropped store data.
- With `DMEM_ALIGN_CHECK_EN`: a load from `addr=0x6` sets `misaligned=1` and returns word 1. The flag stays 1 across later aligned accesses until reset.
